uart_alu_ctrl: RTL
==================

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data word width in bits (FIFO word width).
REQ-002 The block SHALL have parameter OPW, default 6, meaning opcode width in bits (taken from the LSBs of the opcode byte).
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, meaning the number of consecutive empty-RX cycles mid-frame before abort; 0 disables the abort.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_rx_empty  in  1  RX FIFO empty flag.
REQ-007 i_rx_data  in  DBIT  RX FIFO head word, valid whenever i_rx_empty=0.
REQ-008 o_rx_rd  out  1  RX FIFO pop strobe.
REQ-009 i_tx_full  in  1  TX FIFO full flag.
REQ-010 o_tx_wr  out  1  TX FIFO push strobe.
REQ-011 o_tx_data  out  DBIT  TX FIFO write word.
REQ-012 o_a, o_b  out  DBIT each  registered ALU operands.
REQ-013 o_op  out  OPW  registered ALU opcode.
REQ-014 i_alu_result  in  DBIT  combinational ALU result for o_a/o_b/o_op.
REQ-015 o_busy  out  1  high whenever state != S_A.
REQ-016 o_err  out  1  one-cycle registered pulse on timeout abort.

Function
REQ-017 The FSM SHALL have five states: S_A, S_B, S_OP, S_EXEC, S_SEND.
REQ-018 In each of S_A, S_B and S_OP, when i_rx_empty=0, the block SHALL assert o_rx_rd for exactly that cycle, capture i_rx_data into o_a / o_b / o_op[OPW-1:0] respectively, and advance to the next state.
REQ-019 The block SHALL NOT assert o_rx_rd when i_rx_empty=1 or in S_EXEC/S_SEND; o_rx_rd SHALL be a combinational function of state and i_rx_empty.
REQ-020 S_EXEC SHALL last one cycle, latching i_alu_result into the result register, then go to S_SEND.
REQ-021 In S_SEND, the block SHALL drive o_tx_data=result, assert o_tx_wr only when i_tx_full=0, and then return to S_A.
REQ-022 While i_tx_full=1 in S_SEND, the block SHALL hold the state and result and keep o_tx_wr=0.
REQ-023 Minimum frame latency SHALL be 5 cycles, from the first pop to the TX write, with RX non-empty and TX not full throughout.
REQ-024 The timeout counter SHALL clear on every pop and on entry to S_A, and SHALL increment each cycle in S_B or S_OP while i_rx_empty=1.
REQ-025 When the timeout counter reaches TIMEOUT (with TIMEOUT>0), the block SHALL return to S_A next cycle, discard partial operands (o_a/o_b/o_op keep their last values, no TX write), and pulse o_err for one cycle.
REQ-026 S_A SHALL never time out; an idle link is not an error.
REQ-027 The counter width SHALL be $clog2(TIMEOUT+1), with saturation not required because abort occurs at TIMEOUT.
REQ-028 Back-to-back frames SHALL be supported: S_SEND to S_A with no idle cycle, and a pop allowed in the first S_A cycle.

Reset
REQ-029 On i_reset=1, the block SHALL asynchronously set state=S_A; o_a, o_b, o_op, result, o_tx_data and the counter to 0; and o_err to 0.
REQ-030 During reset, o_rx_rd and o_tx_wr SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first word popped after release SHALL be treated as operand A.

Structure
REQ-032 The state encoding localparams and the default DBIT/OPW SHALL reside in shared package uart_alu_pkg.
REQ-033 The ALU SHALL be external; no sub-module is required.
REQ-034 The timeout counter SHALL be inline.
REQ-035 The FSM SHALL be a state register plus a combinational next-state/output block.

Verification
REQ-036 After reset, preload RX with 0x05, 0x03, 0x20 and an adder ALU model -> o_rx_rd high for 3 consecutive cycles, then o_tx_wr for 1 cycle with o_tx_data=0x08 at cycle 5.
REQ-037 In S_SEND with i_tx_full=1 for 10 cycles -> o_tx_wr=0 and o_tx_data stable; i_tx_full drops -> single write of the same value on that cycle.
REQ-038 With TIMEOUT=16, push only 0x05 -> o_err pulses once after 16 empty cycles and o_busy=0; then push 0x02, 0x04, 0x20 -> TX receives 0x06.
REQ-039 Preload 6 bytes (two frames) -> two TX writes 5 cycles apart, with no pop while RX empty.
REQ-040 Assert reset after A and B are popped -> all outputs 0 and state S_A; next 3 bytes form a correct new frame.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU controller: the state encoding
// and the default word widths.
package uart_alu_pkg;

    localparam int DBIT_DEF = 8;
    localparam int OPW_DEF  = 6;

    localparam logic [2:0] ST_A    = 3'd0;
    localparam logic [2:0] ST_B    = 3'd1;
    localparam logic [2:0] ST_OP   = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    typedef enum logic [2:0] {
        S_A    = ST_A,
        S_B    = ST_B,
        S_OP   = ST_OP,
        S_EXEC = ST_EXEC,
        S_SEND = ST_SEND
    } state_t;

endpackage

// File: rtl/uart_alu_ctrl.sv
// Pops A, B and opcode bytes from the RX FIFO, presents them to an external
// ALU, and pushes the result into the TX FIFO; stalled frames time out.
//
// state  | meaning
// S_A    | idle / waiting for operand A (never times out)
// S_B    | waiting for operand B
// S_OP   | waiting for opcode byte
// S_EXEC | latch ALU result
// S_SEND | push result when TX has room
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = 1000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx_empty,
    input  logic [DBIT-1:0] i_rx_data,
    output logic            o_rx_rd,
    input  logic            i_tx_full,
    output logic            o_tx_wr,
    output logic [DBIT-1:0] o_tx_data,
    output logic [DBIT-1:0] o_a,
    output logic [DBIT-1:0] o_b,
    output logic [OPW-1:0]  o_op,
    input  logic [DBIT-1:0] i_alu_result,
    output logic            o_busy,
    output logic            o_err
);

    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam int          CW      = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [DBIT-1:0] result_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rx_rd, tx_wr, abort;

    always_comb begin
        state_d = state_q;
        rx_rd   = 1'b0;
        tx_wr   = 1'b0;
        abort   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_A: begin
                cnt_d = '0;
                if (!i_rx_empty) begin
                    rx_rd   = 1'b1;
                    state_d = S_B;
                end
            end
            S_B, S_OP: begin
                if (!i_rx_empty) begin
                    rx_rd   = 1'b1;
                    cnt_d   = '0;
                    state_d = (state_q == S_B) ? S_OP : S_EXEC;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    // this empty cycle is the TIMEOUT-th one: abandon the frame
                    abort   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: state_d = S_SEND;
            S_SEND: begin
                if (!i_tx_full) begin
                    tx_wr   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_A;
            o_a      <= '0;
            o_b      <= '0;
            o_op     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            o_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_err   <= abort;
            if (rx_rd && state_q == S_A)  o_a  <= i_rx_data;
            if (rx_rd && state_q == S_B)  o_b  <= i_rx_data;
            if (rx_rd && state_q == S_OP) o_op <= i_rx_data[OPW-1:0];
            if (state_q == S_EXEC)        result_q <= i_alu_result;
        end
    end

    assign o_rx_rd   = rx_rd && !i_reset;
    assign o_tx_wr   = tx_wr && !i_reset;
    assign o_tx_data = result_q;
    assign o_busy    = (state_q != S_A);

endmodule
